// File: rtl/bt656_pkg.sv
// Shared types and constants for the BT.656 decoder.
// Build option: define BT656_PROTECT_CHECK_EN to validate the XY protection bits.
package bt656_pkg;

    // Decoder FSM states: HUNT/Z1/Z2/XY locate the timing code, ACTIVE/SKIP follow it
    typedef enum logic [2:0] {
        ST_HUNT   = 3'd0,
        ST_Z1     = 3'd1,
        ST_Z2     = 3'd2,
        ST_XY     = 3'd3,
        ST_ACTIVE = 3'd4,
        ST_SKIP   = 3'd5
    } state_e;

    // Position of the current byte inside a Cb-Y0-Cr-Y1 pair
    typedef enum logic [1:0] {
        PH_CB = 2'd0,
        PH_Y0 = 2'd1,
        PH_CR = 2'd2,
        PH_Y1 = 2'd3
    } phase_e;

    localparam logic [7:0] TRS_FF = 8'hFF;
    localparam logic [7:0] TRS_00 = 8'h00;

    // Expected protection nibble {P3,P2,P1,P0} for a given F/V/H
    function automatic logic [3:0] protect_bits(input logic f, input logic v, input logic h);
        return {v ^ h, f ^ h, f ^ v, f ^ v ^ h};
    endfunction

endpackage

// File: rtl/bt656_trs_detect.sv
// Timing reference detection: FF,00,00 preamble tracking and XY flag decode.
// Build option: BT656_PROTECT_CHECK_EN adds the XY[3:0] protection check.
module bt656_trs_detect
    import bt656_pkg::*;
(
    input  state_e      state_i,
    input  logic [7:0]  byte_i,
    output state_e      next_o,
    output logic        xy_ok_o,
    output logic        xy_err_o,
    output logic        f_o,
    output logic        v_o,
    output logic        h_o
);

    logic prot_ok;
    logic xy_valid;

`ifdef BT656_PROTECT_CHECK_EN
    assign prot_ok = (byte_i[3:0] == protect_bits(byte_i[6], byte_i[5], byte_i[4]));
`else
    logic unused_prot_bits;
    assign unused_prot_bits = ^byte_i[3:0];
    assign prot_ok          = 1'b1;
`endif

    assign f_o      = byte_i[6];
    assign v_o      = byte_i[5];
    assign h_o      = byte_i[4];
    assign xy_valid = byte_i[7] & prot_ok;
    assign xy_ok_o  = (state_i == ST_XY) &  xy_valid;
    assign xy_err_o = (state_i == ST_XY) & ~xy_valid;

    // Preamble walk and the branch taken on the XY byte
    always_comb begin
        next_o = ST_HUNT;
        case (state_i)
            ST_HUNT: next_o = (byte_i == TRS_FF) ? ST_Z1 : ST_HUNT;
            ST_Z1: begin
                if (byte_i == TRS_00)      next_o = ST_Z2;
                else if (byte_i == TRS_FF) next_o = ST_Z1;
                else                       next_o = ST_HUNT;
            end
            ST_Z2: begin
                if (byte_i == TRS_00)      next_o = ST_XY;
                else if (byte_i == TRS_FF) next_o = ST_Z1;
                else                       next_o = ST_HUNT;
            end
            ST_XY: begin
                if (!xy_valid || h_o) next_o = ST_HUNT;
                else if (v_o)         next_o = ST_SKIP;
                else                  next_o = ST_ACTIVE;
            end
            default: next_o = ST_HUNT;
        endcase
    end

endmodule

// File: rtl/bt656_decoder.sv
// BT.656 byte-stream decoder: timing-code tracking, pixel pair assembly,
// line/field counters and error strobes.
// Build option: BT656_PROTECT_CHECK_EN enables the XY protection check.
module bt656_decoder
    import bt656_pkg::*;
#(
    parameter int MAX_PAIRS = 360,
    parameter int LINE_W    = 10
) (
    input  logic              LLC1,
    input  logic              RESET,
    input  logic [7:0]        P15_8,
    output logic [7:0]        cb,
    output logic [7:0]        y0,
    output logic [7:0]        cr,
    output logic [7:0]        y1,
    output logic              pair_valid,
    output logic [LINE_W-1:0] pair_x,
    output logic [LINE_W-1:0] line_cnt,
    output logic              field,
    output logic              vblank,
    output logic              line_start,
    output logic              field_start,
    output logic              sync_err,
    output state_e            dbg_state_o
);

    localparam logic [LINE_W-1:0] PAIR_LIMIT = LINE_W'(MAX_PAIRS);

    state_e            state_q, state_d, det_next;
    phase_e            phase_q;
    logic [7:0]        cb_q, y0_q, cr_q, y1_q;
    logic              pair_valid_q, line_start_q, field_start_q, sync_err_q;
    logic [LINE_W-1:0] pair_x_q, line_cnt_q;
    logic              field_q, vblank_q, first_q;
    logic              xy_ok, xy_err, xy_f, xy_v, xy_h;
    logic              is_ff, take_byte, pair_done, err_d, sav_active;

    assign is_ff = (P15_8 == TRS_FF);

    bt656_trs_detect u_trs (
        .state_i  (state_q),
        .byte_i   (P15_8),
        .next_o   (det_next),
        .xy_ok_o  (xy_ok),
        .xy_err_o (xy_err),
        .f_o      (xy_f),
        .v_o      (xy_v),
        .h_o      (xy_h)
    );

    // FSM state register
    always_ff @(posedge LLC1 or posedge RESET) begin
        if (RESET) state_q <= ST_HUNT;
        else       state_q <= state_d;
    end

    // Next state: ACTIVE/SKIP handled here, preamble states by the detector
    always_comb begin
        state_d = det_next;
        case (state_q)
            ST_ACTIVE: begin
                if (is_ff)                      state_d = ST_Z1;
                else if (pair_x_q == PAIR_LIMIT) state_d = ST_HUNT;
                else                            state_d = ST_ACTIVE;
            end
            ST_SKIP: state_d = is_ff ? ST_Z1 : ST_SKIP;
            default: state_d = det_next;
        endcase
    end

    // Per-cycle controls; an FF in ACTIVE outranks the pair-count overflow
    always_comb begin
        take_byte  = 1'b0;
        pair_done  = 1'b0;
        err_d      = 1'b0;
        sav_active = 1'b0;
        case (state_q)
            ST_XY: begin
                err_d      = xy_err;
                sav_active = xy_ok & ~xy_h & ~xy_v;
            end
            ST_ACTIVE: begin
                if (is_ff) begin
                    err_d = (phase_q != PH_CB);
                end else if (pair_x_q == PAIR_LIMIT) begin
                    err_d = 1'b1;
                end else begin
                    take_byte = 1'b1;
                    pair_done = (phase_q == PH_Y1);
                end
            end
            default: ;
        endcase
    end

    // Pixel byte capture, pair strobe and pair index (advances after the strobe)
    always_ff @(posedge LLC1 or posedge RESET) begin
        if (RESET) begin
            phase_q      <= PH_CB;
            cb_q         <= '0;
            y0_q         <= '0;
            cr_q         <= '0;
            y1_q         <= '0;
            pair_valid_q <= 1'b0;
            pair_x_q     <= '0;
        end else begin
            pair_valid_q <= pair_done;
            phase_q      <= take_byte ? phase_e'(phase_q + 2'd1) : PH_CB;
            if (take_byte) begin
                case (phase_q)
                    PH_CB: cb_q <= P15_8;
                    PH_Y0: y0_q <= P15_8;
                    PH_CR: cr_q <= P15_8;
                    PH_Y1: y1_q <= P15_8;
                    default: ;
                endcase
            end
            if (sav_active)        pair_x_q <= '0;
            else if (pair_valid_q) pair_x_q <= pair_x_q + LINE_W'(1);
        end
    end

    // Field/blanking flags, line counting and the one-cycle strobes
    always_ff @(posedge LLC1 or posedge RESET) begin
        if (RESET) begin
            field_q       <= 1'b0;
            vblank_q      <= 1'b1;
            first_q       <= 1'b1;
            line_cnt_q    <= '0;
            line_start_q  <= 1'b0;
            field_start_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            line_start_q  <= sav_active;
            field_start_q <= sav_active & first_q;
            sync_err_q    <= err_d;
            if (xy_ok) begin
                field_q  <= xy_f;
                vblank_q <= xy_v;
            end
            if (sav_active) begin
                line_cnt_q <= first_q ? '0 : line_cnt_q + LINE_W'(1);
                first_q    <= 1'b0;
            end else if (xy_ok && xy_v) begin
                first_q <= 1'b1;
            end
        end
    end

    assign cb          = cb_q;
    assign y0          = y0_q;
    assign cr          = cr_q;
    assign y1          = y1_q;
    assign pair_valid  = pair_valid_q;
    assign pair_x      = pair_x_q;
    assign line_cnt    = line_cnt_q;
    assign field       = field_q;
    assign vblank      = vblank_q;
    assign line_start  = line_start_q;
    assign field_start = field_start_q;
    assign sync_err    = sync_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_bt656_decoder.sv
// Directed bench for bt656_decoder with a pixel-pair scoreboard.
// Honours BT656_PROTECT_CHECK_EN to match the DUT build.
module tb_bt656_decoder;
  import bt656_pkg::*;

  localparam int LINE_W    = 10;
  localparam int MAX_PAIRS = 360;
  localparam int PW        = 32 + LINE_W;

  logic              LLC1  = 1'b0;
  logic              RESET = 1'b1;
  logic [7:0]        P15_8 = 8'h00;
  logic [7:0]        cb, y0, cr, y1;
  logic              pair_valid;
  logic [LINE_W-1:0] pair_x, line_cnt;
  logic              field, vblank, line_start, field_start, sync_err;
  state_e            dbg_state;

  logic [PW-1:0]     exp_q[$];
  logic [PW-1:0]     exp_pair;
  logic [LINE_W-1:0] exp_lc = '0;
  int                n_vec    = 0;
  int                n_fail   = 0;
  int                serr_cnt = 0;
  int                exp_serr = 0;

  bt656_decoder #(.MAX_PAIRS(MAX_PAIRS), .LINE_W(LINE_W)) dut (
    .LLC1        (LLC1),
    .RESET       (RESET),
    .P15_8       (P15_8),
    .cb          (cb),
    .y0          (y0),
    .cr          (cr),
    .y1          (y1),
    .pair_valid  (pair_valid),
    .pair_x      (pair_x),
    .line_cnt    (line_cnt),
    .field       (field),
    .vblank      (vblank),
    .line_start  (line_start),
    .field_start (field_start),
    .sync_err    (sync_err),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 LLC1 = ~LLC1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // scoreboard monitor: pops one expected pair per strobe, counts error pulses
  always @(posedge LLC1) begin
    #1;
    if (!RESET) begin
      if (sync_err) serr_cnt++;
      if (pair_valid) begin
        if (exp_q.size() == 0) begin
          check("pair_unexpected", {63'd0, pair_valid}, 64'd0);
        end else begin
          exp_pair = exp_q.pop_front();
          check("pair_data", {22'd0, cb, y0, cr, y1, pair_x}, {22'd0, exp_pair});
        end
      end
    end
  end

  // driver tasks: byte changes on negedge, returns 1 time unit after the sampling posedge
  task automatic send_byte(input logic [7:0] b);
    @(negedge LLC1);
    P15_8 = b;
    @(posedge LLC1);
    #1;
  endtask

  task automatic send_trs(input logic [7:0] xy);
    send_byte(8'hFF);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(xy);
  endtask

  task automatic send_pair(input logic [7:0] c_b, input logic [7:0] l0, input logic [7:0] c_r,
                           input logic [7:0] l1, input int idx);
    exp_q.push_back({c_b, l0, c_r, l1, LINE_W'(idx)});
    send_byte(c_b);
    send_byte(l0);
    send_byte(c_r);
    send_byte(l1);
  endtask

  task automatic send_rand_pair(input int idx);
    send_pair(8'($urandom_range(0, 254)), 8'($urandom_range(0, 254)),
              8'($urandom_range(0, 254)), 8'($urandom_range(0, 254)), idx);
  endtask

  // active SAV plus checks of the line strobes against the line-count model
  task automatic sav_check(input logic [7:0] xy, input logic exp_fs, input string tag);
    send_trs(xy);
    if (exp_fs) exp_lc = '0;
    else        exp_lc = exp_lc + LINE_W'(1);
    check({tag, "_line_start"}, {63'd0, line_start}, 64'd1);
    check({tag, "_field_start"}, {63'd0, field_start}, {63'd0, exp_fs});
    check({tag, "_line_cnt"}, {54'd0, line_cnt}, {54'd0, exp_lc});
    check({tag, "_vblank"}, {63'd0, vblank}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cb"}, {56'd0, cb}, 64'd0);
    check({tag, "_y0"}, {56'd0, y0}, 64'd0);
    check({tag, "_cr"}, {56'd0, cr}, 64'd0);
    check({tag, "_y1"}, {56'd0, y1}, 64'd0);
    check({tag, "_pair_valid"}, {63'd0, pair_valid}, 64'd0);
    check({tag, "_pair_x"}, {54'd0, pair_x}, 64'd0);
    check({tag, "_line_cnt"}, {54'd0, line_cnt}, 64'd0);
    check({tag, "_field"}, {63'd0, field}, 64'd0);
    check({tag, "_vblank"}, {63'd0, vblank}, 64'd1);
    check({tag, "_line_start"}, {63'd0, line_start}, 64'd0);
    check({tag, "_field_start"}, {63'd0, field_start}, 64'd0);
    check({tag, "_sync_err"}, {63'd0, sync_err}, 64'd0);
    check({tag, "_state"}, {61'd0, dbg_state}, {61'd0, ST_HUNT});
  endtask

  // let the monitor catch up before reading its counters
  task automatic settle();
    #2;
  endtask

  task automatic check_tallies(input string tag);
    settle();
    check({tag, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_sync_err_count"}, 64'(serr_cnt), 64'(exp_serr));
  endtask

  initial begin
    // reset state
    RESET = 1'b1;
    repeat (3) @(posedge LLC1);
    #1;
    check_reset_outputs("reset");
    @(negedge LLC1);
    RESET = 1'b0;

    // single pair after SAV 80
    sav_check(8'h80, 1'b1, "sav_first");
    check("sav_first_field", {63'd0, field}, 64'd0);
    send_pair(8'h10, 8'h20, 8'h30, 8'h40, 0);
    send_trs(8'h9D);
    check_tallies("single_pair");

    // full line of MAX_PAIRS pairs closed by EAV
    sav_check(8'h80, 1'b0, "full_line");
    for (int i = 0; i < MAX_PAIRS; i++) send_rand_pair(i);
    send_trs(8'h9D);
    check("full_line_state", {61'd0, dbg_state}, {61'd0, ST_HUNT});
    check_tallies("full_line");

    // field sequence: EAV with V=1, then two SAVs
    send_trs(8'hB6);
    check("eav_b6_vblank", {63'd0, vblank}, 64'd1);
    check("eav_b6_line_start", {63'd0, line_start}, 64'd0);
    sav_check(8'h80, 1'b1, "field_sav1");
    sav_check(8'h80, 1'b0, "field_sav2");
    send_trs(8'h9D);
    check_tallies("field_seq");

    // pair count overflow with no timing code
    sav_check(8'h80, 1'b0, "overflow");
    for (int i = 0; i < MAX_PAIRS; i++) send_rand_pair(i);
    send_byte(8'h55);
    send_byte(8'h66);
    exp_serr++;
    check("overflow_sync_err", {63'd0, sync_err}, 64'd1);
    check("overflow_state", {61'd0, dbg_state}, {61'd0, ST_HUNT});
    for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(1, 254)));
    check_tallies("overflow");

    // FF inside a pair: partial pair dropped, resync on 00,00,9D
    sav_check(8'h80, 1'b0, "partial");
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'hFF);
    exp_serr++;
    check("partial_sync_err", {63'd0, sync_err}, 64'd1);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h9D);
    check("partial_sync_err_clear", {63'd0, sync_err}, 64'd0);
    send_byte(8'h12);
    check("partial_state", {61'd0, dbg_state}, {61'd0, ST_HUNT});
    sav_check(8'hC7, 1'b0, "resync");
    check("resync_field", {63'd0, field}, 64'd1);
    send_pair(8'h01, 8'h02, 8'h03, 8'h04, 0);
    send_trs(8'h9D);
    check("resync_field_after_eav", {63'd0, field}, 64'd0);
    check_tallies("partial");

    // SAV with corrupted protection bits
    send_trs(8'h81);
`ifdef BT656_PROTECT_CHECK_EN
    exp_serr++;
    check("prot_sync_err", {63'd0, sync_err}, 64'd1);
    check("prot_line_start", {63'd0, line_start}, 64'd0);
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h07);
    send_byte(8'h08);
`else
    exp_lc = exp_lc + LINE_W'(1);
    check("prot_sync_err", {63'd0, sync_err}, 64'd0);
    check("prot_line_start", {63'd0, line_start}, 64'd1);
    check("prot_line_cnt", {54'd0, line_cnt}, {54'd0, exp_lc});
    send_pair(8'h05, 8'h06, 8'h07, 8'h08, 0);
`endif
    send_trs(8'h9D);
    check_tallies("protect");

    // reset mid-pair, then data with no SAV
    sav_check(8'h80, 1'b0, "mid_reset");
    send_byte(8'h11);
    send_byte(8'h22);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    @(negedge LLC1);
    RESET = 1'b0;
    for (int i = 0; i < 12; i++) send_byte(8'($urandom_range(1, 254)));
    check_reset_outputs("post_reset");
    check_tallies("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
